// File: rtl/lsu_mem_master.sv
// RV32I load/store unit driving a word-organised single-cycle data memory.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
module lsu_mem_master #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, RESP
  } state_t;

  state_t      state;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        rd_q, wr_q, resp_q, err_q;
  logic [31:0] data_q, addr_q, wdat_q;

  logic        ld_ok, st_ok, misal, oor, bad;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] load_val, merged;

  assign ld_ok = (req_funct3 == 3'b000) | (req_funct3 == 3'b001) |
                 (req_funct3 == 3'b010) | (req_funct3 == 3'b100) |
                 (req_funct3 == 3'b101);
  assign st_ok = ~req_funct3[2] & (req_funct3[1:0] != 2'b11);
  assign misal = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                 ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
  assign oor   = req_addr >= 32'(4 * MEM_WORDS);
  assign bad   = (req_store ? ~st_ok : ~ld_ok) | misal | oor;

  always_comb begin
    lb = 8'(mem_rdata >> {lane_q, 3'b000});
    lh = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  load_val = {{24{lb[7]}}, lb};
      3'b001:  load_val = {{16{lh[15]}}, lh};
      3'b100:  load_val = {24'h0, lb};
      3'b101:  load_val = {16'h0, lh};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      funct3_q <= '0;
      lane_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      resp_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      wdat_q   <= '0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      resp_q <= 1'b0;
      unique case (state)
        IDLE: if (req_valid) begin
          funct3_q <= req_funct3;
          lane_q   <= req_addr[1:0];
          wdata_q  <= req_wdata;
          addr_q   <= {req_addr[31:2], 2'b00};
          data_q   <= '0;
          err_q    <= 1'b0;
          if (bad) begin
            state  <= RESP;
            resp_q <= 1'b1;
            err_q  <= 1'b1;
          end else if (!req_store) begin
            state <= LOAD;
            rd_q  <= 1'b1;
          end else if (req_funct3[1:0] == 2'b10) begin
            state  <= WRITE;
            wr_q   <= 1'b1;
            wdat_q <= req_wdata;
          end else begin
            state <= RMW_RD;
            rd_q  <= 1'b1;
          end
        end
        LOAD: begin
          data_q <= load_val;
          resp_q <= 1'b1;
          state  <= RESP;
        end
        RMW_RD: begin
          wdat_q <= merged;
          wr_q   <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          resp_q <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced quiet combinationally so a reset cycle never strobes.
  assign req_ready  = (state == IDLE) & ~reset;
  assign resp_valid = resp_q & ~reset;
  assign resp_error = err_q & resp_q & ~reset;
  assign resp_data  = reset ? 32'h0 : data_q;
  assign mem_read   = rd_q & ~reset;
  assign mem_write  = wr_q & ~reset;
  assign mem_addr   = reset ? 32'h0 : addr_q;
  assign mem_wdata  = reset ? 32'h0 : wdat_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed table, reset/back-to-back sequences,
// and random accesses checked against an arithmetic memory model.
module tb_lsu_mem_master;
  localparam int MEM_WORDS = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_mem_master #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  bit [31:0] mem [MEM_WORDS];
  bit [31:0] ref_mem [MEM_WORDS];

  assign mem_rdata = mem_read ? mem[mem_addr[7:2]] : 32'h0;
  always @(posedge clk)
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  int n_cmp = 0;
  int n_fail = 0;
  int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0;
  int overlap = 0, idle_bad = 0;

  always @(negedge clk) begin
    if (mem_read && mem_write) overlap++;
    if (req_ready && (mem_read || mem_write || resp_valid)) idle_bad++;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (resp_valid) resp_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model(input bit st, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd,
                       output bit [31:0] d, output bit e,
                       output int lat, output int nrd, output int nwr);
    bit legal;
    int sz, sh;
    bit [31:0] w, mask;
    legal = st ? (f3 <= 3'd2)
               : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    sz = 1 << f3[1:0];
    d = 0; e = 0; lat = 0; nrd = 0; nwr = 0;
    if (!legal || (a % sz) != 0 || a >= 4 * MEM_WORDS) begin
      e = 1;
      lat = 1;
      return;
    end
    w = ref_mem[a / 4];
    sh = (a % 4) * 8;
    if (!st) begin
      lat = 2;
      nrd = 1;
      if (sz == 4) d = w;
      else if (sz == 2) begin
        d = (w >> sh) & 32'hFFFF;
        if (f3 == 1 && d >= 32'h8000) d = d - 32'h10000;
      end else begin
        d = (w >> sh) & 32'hFF;
        if (f3 == 0 && d >= 32'h80) d = d - 32'h100;
      end
    end else begin
      nwr = 1;
      if (sz == 4) begin
        ref_mem[a / 4] = wd;
        lat = 2;
      end else begin
        mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[a / 4] = (w & ~mask) | ((wd << sh) & mask);
        lat = 3;
        nrd = 1;
      end
    end
  endtask

  task automatic do_req(input bit st, input bit [2:0] f3,
                        input bit [31:0] a, input bit [31:0] wd,
                        output bit [31:0] d, output bit e,
                        output int lat, output int nrd, output int nwr);
    int r0, w0;
    @(negedge clk);
    req_valid = 1; req_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    #1;
    chk("ready_at_accept", {31'b0, req_ready}, 32'd1);
    r0 = rd_cnt; w0 = wr_cnt;
    lat = -1; d = 0; e = 0;
    @(posedge clk);
    #1 req_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid) begin
        lat = k; d = resp_data; e = resp_error;
        break;
      end
    end
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
  endtask

  typedef struct {
    bit st; bit [2:0] f3; bit [31:0] a; bit [31:0] wd;
    bit [31:0] xd; bit xe; int xlat; int xrd; int xwr;
  } vec_t;

  vec_t tbl[$];

  initial begin
    bit [31:0] d, md;
    bit e, me;
    int lat, nrd, nwr, mlat, mrd, mwr;
    int k1, k2, acc, nresp;
    logic [2:0] ld_codes [5];
    bit st;
    bit [2:0] f3;
    bit [31:0] a, wd;

    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    tbl.push_back('{1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd0, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd4, 32'h13, 32'h0, 32'h000000DE, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd5, 32'h10, 32'h0, 32'h0000BEEF, 0, 2, 1, 0});
    tbl.push_back('{1, 3'd0, 32'h11, 32'h55, 32'h0, 0, 3, 1, 1});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, 1, 0});
    tbl.push_back('{1, 3'd1, 32'h12, 32'h1234, 32'h0, 0, 3, 1, 1});
    tbl.push_back('{0, 3'd2, 32'h10, 32'h0, 32'h123455EF, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd2, 32'h12, 32'h0, 32'h0, 1, 1, 0, 0});
    tbl.push_back('{1, 3'd1, 32'h11, 32'h77, 32'h0, 1, 1, 0, 0});
    tbl.push_back('{0, 3'd0, 32'h100, 32'h0, 32'h0, 1, 1, 0, 0});
    tbl.push_back('{0, 3'd3, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0});
    tbl.push_back('{1, 3'd4, 32'h20, 32'h9, 32'h0, 1, 1, 0, 0});
    tbl.push_back('{1, 3'd2, 32'hFC, 32'h80000001, 32'h0, 0, 2, 0, 1});
    tbl.push_back('{0, 3'd0, 32'hFC, 32'h0, 32'h00000001, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd1, 32'hFE, 32'h0, 32'hFFFF8000, 0, 2, 1, 0});
    tbl.push_back('{0, 3'd2, 32'hFFFFFFFC, 32'h0, 32'h0, 1, 1, 0, 0});

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    reset = 0;
    #1;
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    foreach (tbl[i]) begin
      model(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, md, me, mlat, mrd, mwr);
      do_req(tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, d, e, lat, nrd, nwr);
      chk($sformatf("vec%0d_data", i), d, tbl[i].xd);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, tbl[i].xe});
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].xlat));
      chk($sformatf("vec%0d_reads", i), 32'(nrd), 32'(tbl[i].xrd));
      chk($sformatf("vec%0d_writes", i), 32'(nwr), 32'(tbl[i].xwr));
      if (tbl[i].a < 4 * MEM_WORDS)
        chk($sformatf("vec%0d_mem", i), mem[tbl[i].a[7:2]],
            ref_mem[tbl[i].a[7:2]]);
    end

    // Reset asserted while the SB read-modify-write is reading.
    model(1, 3'd2, 32'h30, 32'hA5A5A5A5, md, me, mlat, mrd, mwr);
    do_req(1, 3'd2, 32'h30, 32'hA5A5A5A5, d, e, lat, nrd, nwr);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'd0;
    req_addr = 32'h30; req_wdata = 32'h11;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    #1;
    chk("abort_rmw_read_seen", {31'b0, mem_read}, 32'd1);
    k1 = wr_cnt; k2 = resp_cnt;
    reset = 1;
    @(negedge clk);
    #1 reset = 0;
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    #1;
    chk("abort_no_write", 32'(wr_cnt - k1), 32'd0);
    chk("abort_no_resp", 32'(resp_cnt - k2), 32'd0);
    chk("abort_word", mem[12], 32'hA5A5A5A5);

    // Back-to-back SW then LW with req_valid held high throughout.
    model(1, 3'd2, 32'h40, 32'h12345678, md, me, mlat, mrd, mwr);
    model(0, 3'd2, 32'h40, 32'h0, md, me, mlat, mrd, mwr);
    @(negedge clk);
    req_valid = 1; req_store = 1; req_funct3 = 3'd2;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    acc = 0; nresp = 0; k1 = -1; k2 = -1;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (req_valid && req_ready) acc++;
      if (resp_valid) begin
        nresp++;
        if (nresp == 1) begin
          k1 = c;
          chk("b2b_sw_data", resp_data, 32'h0);
          req_store = 0;
        end else begin
          k2 = c;
          chk("b2b_lw_data", resp_data, md);
          req_valid = 0;
        end
      end
      @(negedge clk);
    end
    req_valid = 0;
    chk("b2b_accepts", 32'(acc), 32'd2);
    chk("b2b_resps", 32'(nresp), 32'd2);
    chk("b2b_first_lat", 32'(k1), 32'd2);
    chk("b2b_spacing", 32'(k2 - k1), 32'd3);

    // Random accesses against the model.
    for (int i = 0; i < 200; i++) begin
      st = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
      else if (st) f3 = 3'($urandom_range(0, 2));
      else f3 = ld_codes[$urandom_range(0, 4)];
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 19) == 0) a = $urandom;
      wd = $urandom;
      model(st, f3, a, wd, md, me, mlat, mrd, mwr);
      do_req(st, f3, a, wd, d, e, lat, nrd, nwr);
      chk($sformatf("rnd%0d_data", i), d, md);
      chk($sformatf("rnd%0d_err", i), {31'b0, e}, {31'b0, me});
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(mlat));
      chk($sformatf("rnd%0d_strobes", i), 32'(nrd * 2 + nwr),
          32'(mrd * 2 + mwr));
      if (a < 4 * MEM_WORDS)
        chk($sformatf("rnd%0d_mem", i), mem[a[7:2]], ref_mem[a[7:2]]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    chk("strobe_overlap", 32'(overlap), 32'd0);
    chk("idle_activity", 32'(idle_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store unit that initiates accesses to the word-organised, single-cycle data memory on behalf of the core.
- Converts RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-granular memory transactions:
  - loads: sub-word byte/halfword extraction with sign or zero extension;
  - sub-word stores: read-modify-write.
- Sits between the execute stage (request/response handshake) and the data memory (mem_read/mem_write/address/data).

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; byte addresses at or above 4*MEM_WORDS are out of range.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept a request (high only in IDLE)
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I funct3 size/sign code
- req_addr  input  32  byte address
- req_wdata  input  32  store data (low byte/half used for SB/SH)
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid
- mem_read  output  1  read strobe to data memory
- mem_write  output  1  write strobe to data memory
- mem_addr  output  32  word-aligned byte address ({addr[31:2],2'b00})
- mem_wdata  output  32  full word to write
- mem_rdata  input  32  combinational read data, valid in the same cycle mem_read is high

Behaviour:
- Clock and reset:
  - Clock clk; reset is synchronous, active-high.
  - While reset is high: state goes to IDLE; all registers clear. req_ready, resp_valid, resp_error, mem_read and mem_write are 0; resp_data, mem_addr and mem_wdata are 0.
  - mem_write is gated low whenever reset=1.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready=1 (when reset=0).
  - Accept when req_valid & req_ready. Latch store flag, funct3, addr and wdata.
  - Decode, then branch:
    - error → RESP, with resp_error=1 and no memory strobe ever asserted;
    - load → LOAD;
    - SW → WRITE;
    - SB/SH → RMW_RD.
- Error conditions:
  - Loads: funct3 not in {000,001,010,100,101}.
  - Stores: funct3 not in {000,001,010}.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - addr ≥ 4*MEM_WORDS.
- LOAD:
  - mem_read=1 and mem_addr=word address.
  - On the edge, extract from mem_rdata and register into resp_data. Byte lane is addr[1:0]; halfword lane is addr[1].
  - Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - → RESP.
- RMW_RD:
  - mem_read=1.
  - On the edge, register the merged word: mem_rdata with the addressed lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH).
  - → WRITE.
- WRITE:
  - mem_write=1; mem_wdata = merged word, or wdata for SW; mem_addr = word address.
  - The memory commits on this cycle's rising edge.
  - → RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_data/resp_error stable.
  - → IDLE. No response backpressure.
- Strobes: mem_read and mem_write are never high in the same cycle, and never high in IDLE or RESP.
- Latency (accept edge = cycle 0; resp_valid cycle):
  - LW/LB/LH/LBU/LHU: 2.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Throughput: the next request is accepted in the cycle after RESP. req_valid outside IDLE is ignored; the core holds it.
- Reset mid-operation: abort to IDLE on the next edge. No resp_valid pulse and no further strobe for the aborted op. A write in progress is suppressed by the mem_write gating.
- Memory reset: the data memory reset also clears memory contents; the unit imposes no ordering on it.

Test Plan:
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 → mem_write pulse cycle 1; LW resp_valid at cycle 2 with resp_data=0xDEADBEEF, resp_error=0.
- After that, LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB addr=0x11 data=0x55, then LW 0x10 → one RMW_RD read, then write 0xDEAD55EF; resp at cycle 3; LW returns 0xDEAD55EF. SH 0x12 data=0x1234 → word becomes 0x123455EF.
- Errors, each giving resp_valid cycle 1, resp_error=1, resp_data=0, no mem_read/mem_write:
  - LW 0x12;
  - SH 0x11;
  - LB 0x100 (MEM_WORDS=64);
  - load funct3=011.
- Issue SB, assert reset during the RMW_RD cycle → no mem_write, no resp_valid, req_ready=1 after reset drops; target word unchanged.
- Back-to-back SW/LW with req_valid held high → req_ready low in LOAD/WRITE/RESP; each request accepted exactly once; strobes never overlap.
